// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-port ALU arbiter.
// Opcodes, FSM encodings and flag bit positions.
package alu_arbiter_pkg;

   localparam logic [1:0] OP_OR  = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b01;

   localparam int FLG_OVF  = 1;
   localparam int FLG_SIGN = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic op_legal(input logic [1:0] op);
      return (op == OP_OR) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit OR/SUB ALU, purely combinational.
// Overflow is the signed-subtract rule, evaluated for any op.
module alu8
   import alu_arbiter_pkg::*;
(
   input  logic [1:0] op_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] result_o,
   output logic       ovf_o,
   output logic       sign_o
);

   always_comb begin
      result_o = 8'h00;
      unique case (op_i)
         OP_OR:   result_o = a_i | b_i;
         OP_SUB:  result_o = a_i - b_i;
         default: result_o = 8'h00;
      endcase
   end

   assign ovf_o  = (a_i[7] ^ b_i[7]) & (result_o[7] ^ a_i[7]);
   assign sign_o = result_o[7];

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way combinational grant with round-robin pointer
// or fixed port-0 priority on contention.
module rr_arbiter2 #(
   parameter int FIXED_PRIORITY = 0
) (
   input  logic [1:0] valid_i,
   input  logic       ptr_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      unique case (valid_i)
         2'b11: begin
            if (FIXED_PRIORITY != 0 || !ptr_i) gnt_o = 2'b01;
            else                               gnt_o = 2'b10;
         end
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one OR/SUB ALU between issue (port 0) and debug (port 1)
// with captured operands and registered, held responses.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int FIXED_PRIORITY = 0,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req_op0,
   input  logic [1:0]       req_op1,
   input  logic [7:0]       req_a0,
   input  logic [7:0]       req_b0,
   input  logic [7:0]       req_a1,
   input  logic [7:0]       req_b1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ack,
   output logic [7:0]       rsp_result,
   output logic [1:0]       rsp_flags,
   output logic             rsp_error,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [7:0]       a_q, a_d;
   logic [7:0]       b_q, b_d;
   logic             owner_q, owner_d;
   logic             rr_q, rr_d;
   logic [7:0]       result_q, result_d;
   logic [1:0]       flags_q, flags_d;
   logic             error_q, error_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0] gnt;
   logic [1:0] sel_op;
   logic [7:0] sel_a, sel_b;
   logic [7:0] alu_res;
   logic       alu_ovf, alu_sign;

   rr_arbiter2 #(
      .FIXED_PRIORITY(FIXED_PRIORITY)
   ) u_arb (
      .valid_i(req_valid),
      .ptr_i  (rr_q),
      .gnt_o  (gnt)
   );

   alu8 u_alu (
      .op_i    (op_q),
      .a_i     (a_q),
      .b_i     (b_q),
      .result_o(alu_res),
      .ovf_o   (alu_ovf),
      .sign_o  (alu_sign)
   );

   assign sel_op = gnt[1] ? req_op1 : req_op0;
   assign sel_a  = gnt[1] ? req_a1  : req_a0;
   assign sel_b  = gnt[1] ? req_b1  : req_b0;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      result_d = result_q;
      flags_d  = flags_q;
      error_d  = error_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               op_d    = sel_op;
               a_d     = sel_a;
               b_d     = sel_b;
               owner_d = gnt[1];
               if (op_legal(sel_op)) begin
                  error_d = 1'b0;
                  state_d = ST_EXEC;
               end else begin
                  error_d  = 1'b1;
                  result_d = 8'h00;
                  flags_d  = 2'b00;
                  state_d  = ST_RESP;
               end
            end
         end
         ST_EXEC: begin
            result_d          = alu_res;
            // overflow only means something for subtract
            flags_d[FLG_OVF]  = (op_q == OP_SUB) & alu_ovf;
            flags_d[FLG_SIGN] = alu_sign;
            state_d           = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ack[owner_q]) begin
               cnt_d   = cnt_q + CNT_W'(1);
               rr_d    = ~owner_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= 2'b00;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         owner_q  <= 1'b0;
         rr_q     <= 1'b0;
         result_q <= 8'h00;
         flags_q  <= 2'b00;
         error_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         error_q  <= error_d;
         cnt_q    <= cnt_d;
      end
   end

   // ready is masked during reset so no grant leaks out
   assign req_ready  = (state_q == ST_IDLE && rst_n) ? gnt : 2'b00;
   assign rsp_valid  = (state_q == ST_RESP) ?
                       (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_result = result_q;
   assign rsp_flags  = flags_q;
   assign rsp_error  = error_q;
   assign busy       = (state_q != ST_IDLE);
   assign ops_done   = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: round-robin instance plus
// a fixed-priority instance sharing the same stimulus.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid, rsp_ack;
   logic [1:0] req_op0, req_op1;
   logic [7:0] req_a0, req_b0, req_a1, req_b1;

   logic [1:0]  req_ready, rsp_valid, rsp_flags;
   logic [7:0]  rsp_result;
   logic        rsp_error, busy;
   logic [15:0] ops_done;

   logic [1:0]  rdy_f, rv_f, flg_f;
   logic [7:0]  res_f;
   logic        err_f, busy_f;
   logic [15:0] ops_f;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_ops  = 0;

   typedef struct {
      int         port;
      logic [7:0] result;
      logic [1:0] flags;
      logic       error;
      int         lat;
   } exp_t;

   typedef struct {
      bit         acc_ok;
      logic [1:0] ready;
      int         lat;
      logic [1:0] valid;
      logic [7:0] result;
      logic [1:0] flags;
      logic       error;
      logic [1:0] valid_after;
   } obs_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   alu_arbiter #(.FIXED_PRIORITY(0), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_b0(req_b0),
      .req_a1(req_a1), .req_b1(req_b1),
      .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .rsp_error(rsp_error), .busy(busy), .ops_done(ops_done)
   );

   alu_arbiter #(.FIXED_PRIORITY(1), .CNT_W(16)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(rdy_f),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_a0(req_a0), .req_b0(req_b0),
      .req_a1(req_a1), .req_b1(req_b1),
      .rsp_valid(rv_f), .rsp_ack(rsp_ack),
      .rsp_result(res_f), .rsp_flags(flg_f),
      .rsp_error(err_f), .busy(busy_f), .ops_done(ops_f)
   );

   function automatic exp_t model(input int p, input logic [1:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.port = p;
      e.error = 1'b0;
      e.lat = 2;
      if (op == 2'b10) begin
         e.result = a | b;
         e.flags  = {1'b0, e.result[7]};
      end else if (op == 2'b01) begin
         e.result = a - b;
         e.flags  = {(a[7] != b[7]) && (e.result[7] != a[7]), e.result[7]};
      end else begin
         e.result = 8'h00;
         e.flags  = 2'b00;
         e.error  = 1'b1;
         e.lat    = 1;
      end
      return e;
   endfunction

   task automatic xact(input int p, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit ack, output obs_t o);
      int n;
      sb.push_back(model(p, op, a, b));
      o = '{default: 0};
      @(negedge clk);
      if (p == 0) begin
         req_op0 = op; req_a0 = a; req_b0 = b;
      end else begin
         req_op1 = op; req_a1 = a; req_b1 = b;
      end
      req_valid[p] = 1'b1;
      #1;
      n = 0;
      while (req_ready[p] !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      o.acc_ok = (req_ready[p] === 1'b1);
      o.ready  = req_ready;
      @(negedge clk);
      req_valid[p] = 1'b0;
      #1;
      o.lat = 1;
      while (rsp_valid === 2'b00 && o.lat < 20) begin
         @(negedge clk); #1; o.lat++;
      end
      o.valid  = rsp_valid;
      o.result = rsp_result;
      o.flags  = rsp_flags;
      o.error  = rsp_error;
      if (ack) begin
         rsp_ack[p] = 1'b1;
         @(negedge clk);
         rsp_ack[p] = 1'b0;
         #1;
         o.valid_after = rsp_valid;
         exp_ops++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      n_checks++;
      if (req_ready !== 2'b00) begin
         n_fail++; $display("FAIL reset_ready got %b want 00", req_ready);
      end
      n_checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle got valid=%b busy=%b want 00/0", rsp_valid, busy);
      end
      n_checks++;
      if (ops_done !== 16'd0 || rsp_result !== 8'h00 || rsp_flags !== 2'b00) begin
         n_fail++; $display("FAIL reset_regs got ops=%0d res=%h flg=%b want 0/00/00", ops_done, rsp_result, rsp_flags);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL reset_first_grant got %b want 01", req_ready);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_sub();
      obs_t o; exp_t e;
      xact(0, 2'b01, 8'h05, 8'h03, 1'b1, o);
      e = sb.pop_front();
      n_checks++;
      if (!o.acc_ok || o.ready !== 2'b01) begin
         n_fail++; $display("FAIL sub_accept got %b want 01", o.ready);
      end
      n_checks++;
      if (o.lat != e.lat || o.valid !== 2'b01) begin
         n_fail++; $display("FAIL sub_latency got lat=%0d valid=%b want %0d/01", o.lat, o.valid, e.lat);
      end
      n_checks++;
      if (o.result !== e.result || o.flags !== e.flags || o.error !== e.error) begin
         n_fail++; $display("FAIL sub_result got %h/%b/%b want %h/%b/%b", o.result, o.flags, o.error, e.result, e.flags, e.error);
      end
      n_checks++;
      if (o.valid_after !== 2'b00 || ops_done !== 16'(exp_ops)) begin
         n_fail++; $display("FAIL sub_ack got valid=%b ops=%0d want 00/%0d", o.valid_after, ops_done, exp_ops);
      end
   endtask

   task automatic test_flags();
      obs_t o; exp_t e;
      xact(1, 2'b01, 8'h80, 8'h01, 1'b1, o);
      e = sb.pop_front();
      n_checks++;
      if (o.valid !== 2'b10 || o.lat != e.lat) begin
         n_fail++; $display("FAIL ovf_valid got %b lat=%0d want 10 lat=%0d", o.valid, o.lat, e.lat);
      end
      n_checks++;
      if (o.result !== e.result || o.flags !== e.flags) begin
         n_fail++; $display("FAIL ovf_result got %h/%b want %h/%b", o.result, o.flags, e.result, e.flags);
      end
      xact(0, 2'b10, 8'h0F, 8'hF0, 1'b1, o);
      e = sb.pop_front();
      n_checks++;
      if (o.valid !== 2'b01 || o.result !== e.result || o.flags !== e.flags || o.error !== e.error) begin
         n_fail++; $display("FAIL or_sign got %b %h/%b/%b want 01 %h/%b/%b", o.valid, o.result, o.flags, o.error, e.result, e.flags, e.error);
      end
      n_checks++;
      if (ops_done !== 16'(exp_ops)) begin
         n_fail++; $display("FAIL flags_ops got %0d want %0d", ops_done, exp_ops);
      end
   endtask

   task automatic test_illegal();
      obs_t o; exp_t e;
      logic [1:0] ops [2];
      ops[0] = 2'b11;
      ops[1] = 2'b00;
      for (int i = 0; i < 2; i++) begin
         xact(i, ops[i], 8'hAA, 8'h55, 1'b1, o);
         e = sb.pop_front();
         n_checks++;
         if (o.lat != e.lat) begin
            n_fail++; $display("FAIL illegal_lat op=%b got %0d want %0d", ops[i], o.lat, e.lat);
         end
         n_checks++;
         if (o.error !== 1'b1 || o.result !== e.result || o.flags !== e.flags) begin
            n_fail++; $display("FAIL illegal_rsp op=%b got %b/%h/%b want 1/%h/%b", ops[i], o.error, o.result, o.flags, e.result, e.flags);
         end
      end
      n_checks++;
      if (ops_done !== 16'(exp_ops)) begin
         n_fail++; $display("FAIL illegal_ops got %0d want %0d", ops_done, exp_ops);
      end
   endtask

   task automatic test_hold_reset();
      obs_t o; exp_t e;
      int bad;
      xact(0, 2'b01, 8'h10, 8'h01, 1'b0, o);
      e = sb.pop_front();
      n_checks++;
      if (o.valid !== 2'b01 || o.result !== e.result) begin
         n_fail++; $display("FAIL hold_first got %b/%h want 01/%h", o.valid, o.result, e.result);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req_valid = 2'b11;
         rsp_ack = 2'b10;
         #1;
         n_checks++;
         if (rsp_valid !== 2'b01 || rsp_result !== e.result || rsp_flags !== e.flags || req_ready !== 2'b00) begin
            n_fail++; bad++;
            $display("FAIL hold_cycle %0d got v=%b r=%h f=%b rdy=%b want 01/%h/%b/00", i, rsp_valid, rsp_result, rsp_flags, req_ready, e.result, e.flags);
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ack = 2'b00;
      #1;
      sb.delete();
      exp_ops = 0;
      n_checks++;
      if (rsp_valid !== 2'b00 || busy !== 1'b0 || ops_done !== 16'd0) begin
         n_fail++; $display("FAIL hold_reset got v=%b busy=%b ops=%0d want 00/0/0", rsp_valid, busy, ops_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
         n_fail++; $display("FAIL hold_after got busy=%b v=%b want 0/00", busy, rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] want_rr [4];
      int n;
      want_rr[0] = 2'b01; want_rr[1] = 2'b10;
      want_rr[2] = 2'b01; want_rr[3] = 2'b10;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_op0 = 2'b01; req_a0 = 8'h09; req_b0 = 8'h04;
      req_op1 = 2'b10; req_a1 = 8'h30; req_b1 = 8'h03;
      exp_ops = 0;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (req_ready === 2'b00 && n < 20) begin
            @(negedge clk); #1; n++;
         end
         n_checks++;
         if (req_ready !== want_rr[k]) begin
            n_fail++; $display("FAIL rr_grant %0d got %b want %b", k, req_ready, want_rr[k]);
         end
         n_checks++;
         if (rdy_f !== 2'b01) begin
            n_fail++; $display("FAIL fp_grant %0d got %b want 01", k, rdy_f);
         end
         @(negedge clk); #1;
         n = 0;
         while (rsp_valid === 2'b00 && n < 20) begin
            @(negedge clk); #1; n++;
         end
         rsp_ack = 2'b11;
         @(negedge clk);
         rsp_ack = 2'b00;
         exp_ops++;
         #1;
      end
      req_valid = 2'b00;
      n_checks++;
      if (ops_done !== 16'(exp_ops) || ops_f !== 16'(exp_ops)) begin
         n_fail++; $display("FAIL rr_ops got %0d/%0d want %0d", ops_done, ops_f, exp_ops);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ack = 2'b00;
      req_op0 = 2'b00; req_op1 = 2'b00;
      req_a0 = 8'h00; req_b0 = 8'h00;
      req_a1 = 8'h00; req_b1 = 8'h00;
      repeat (2) @(negedge clk);
      test_reset();
      test_sub();
      test_flags();
      test_illegal();
      test_hold_reset();
      test_round_robin();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
